// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mlp_layer_sequencer
// Function : Time-multiplexed single-MAC sequencer for one fully-connected
//            MLP layer with bias, Q-format requantisation and optional ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 10,
    parameter int DW    = 32,
    parameter int FRAC  = 24,
    parameter int ACCW  = 74,
    parameter int RELU  = 1,
    localparam int c_iw = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int c_ww = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int c_ow = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            sat,
    output logic            rd_en,
    output logic [c_iw-1:0] in_addr,
    output logic [c_ww-1:0] w_addr,
    output logic [c_ow-1:0] b_addr,
    input  logic [DW-1:0]   in_data,
    input  logic [DW-1:0]   w_data,
    input  logic [DW-1:0]   b_data,
    output logic            out_we,
    output logic [c_ow-1:0] out_addr,
    output logic [DW-1:0]   out_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [c_iw-1:0]        c_last_i = c_iw'(N_IN - 1);
    localparam logic [c_ow-1:0]        c_last_j = c_ow'(N_OUT - 1);
    localparam logic signed [ACCW-1:0] c_max    = ACCW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [ACCW-1:0] c_min    = ~c_max;

    state_t                 r_state;
    logic                   r_vld;
    logic                   r_vfirst;
    logic signed [ACCW-1:0] r_acc;

    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_x;
    logic signed [ACCW-1:0] w_bias_x;
    logic signed [ACCW-1:0] w_acc_next;
    logic signed [ACCW-1:0] w_shift;
    logic [DW-1:0]          w_result;
    logic                   w_clamp;

    assign w_prod     = $signed(in_data) * $signed(w_data);
    assign w_prod_x   = ACCW'(w_prod);
    assign w_bias_x   = ACCW'($signed(b_data)) <<< FRAC;
    // The first beat of each neuron seeds the accumulator with the aligned bias.
    assign w_acc_next = (r_vfirst ? w_bias_x : r_acc) + w_prod_x;
    assign w_shift    = w_acc_next >>> FRAC;

    always_comb begin
        w_clamp  = 1'b0;
        w_result = w_shift[DW-1:0];
        if (w_shift > c_max) begin
            w_result = c_max[DW-1:0];
            w_clamp  = 1'b1;
        end else if (w_shift < c_min) begin
            w_result = c_min[DW-1:0];
            w_clamp  = 1'b1;
        end
        if (RELU != 0 && w_result[DW-1]) begin
            w_result = '0;
        end
    end

    // Read data lands one cycle after the strobe, so the valid flags trail rd_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld    <= 1'b0;
            r_vfirst <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_vld    <= rd_en;
            r_vfirst <= rd_en && (in_addr == '0);
            if (r_vld) begin
                r_acc <= w_acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
            rd_en    <= 1'b0;
            in_addr  <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_MAC;
                        busy    <= 1'b1;
                        sat     <= 1'b0;
                        rd_en   <= 1'b1;
                        in_addr <= '0;
                        w_addr  <= '0;
                        b_addr  <= '0;
                    end
                end
                S_MAC: begin
                    if (in_addr == c_last_i) begin
                        r_state <= S_DRAIN;
                        rd_en   <= 1'b0;
                    end else begin
                        in_addr <= in_addr + c_iw'(1);
                        w_addr  <= w_addr + c_ww'(1);
                    end
                end
                S_DRAIN: begin
                    r_state  <= S_WRITE;
                    out_we   <= 1'b1;
                    out_addr <= b_addr;
                    out_data <= w_result;
                    sat      <= sat | w_clamp;
                end
                S_WRITE: begin
                    out_we <= 1'b0;
                    if (b_addr == c_last_j) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        // Weight address runs on contiguously into the next row.
                        r_state <= S_MAC;
                        rd_en   <= 1'b1;
                        in_addr <= '0;
                        w_addr  <= w_addr + c_ww'(1);
                        b_addr  <= b_addr + c_ow'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_layer_sequencer
// Function : Directed checks of mlp_layer_sequencer against a latency/arith model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_s, start_d, chk_en;
    int   n_chk = 0;
    int   n_bad = 0;

    logic        busy0, done0, sat0, rd0, we0;
    logic [1:0]  ia0, ba0, oa0;
    logic [3:0]  wa0;
    logic [31:0] id0, wd0, bd0, od0;
    logic        busy1, done1, sat1, rd1, we1;
    logic [1:0]  ia1, ba1, oa1;
    logic [3:0]  wa1;
    logic [31:0] id1, wd1, bd1, od1;
    logic        busy2, done2, sat2, rd2, we2;
    logic [9:0]  ia2;
    logic [12:0] wa2;
    logic [3:0]  ba2, oa2;
    logic [31:0] id2, wd2, bd2, od2;

    mlp_layer_sequencer #(.N_IN(4), .N_OUT(3), .DW(32), .FRAC(24), .ACCW(74), .RELU(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy0), .done(done0), .sat(sat0),
        .rd_en(rd0), .in_addr(ia0), .w_addr(wa0), .b_addr(ba0), .in_data(id0), .w_data(wd0),
        .b_data(bd0), .out_we(we0), .out_addr(oa0), .out_data(od0));
    mlp_layer_sequencer #(.N_IN(4), .N_OUT(3), .DW(32), .FRAC(24), .ACCW(74), .RELU(0)) u_r0 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy1), .done(done1), .sat(sat1),
        .rd_en(rd1), .in_addr(ia1), .w_addr(wa1), .b_addr(ba1), .in_data(id1), .w_data(wd1),
        .b_data(bd1), .out_we(we1), .out_addr(oa1), .out_data(od1));
    mlp_layer_sequencer u_def (
        .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy2), .done(done2), .sat(sat2),
        .rd_en(rd2), .in_addr(ia2), .w_addr(wa2), .b_addr(ba2), .in_data(id2), .w_data(wd2),
        .b_data(bd2), .out_we(we2), .out_addr(oa2), .out_data(od2));

    // Shared memory image; weight row j starts at j*N_IN for each instance.
    logic [31:0] mi [0:783];
    logic [31:0] mw [0:7839];
    logic [31:0] mb [0:9];

    always @(posedge clk) begin
        if (rd0) begin id0 <= mi[ia0]; wd0 <= mw[wa0]; bd0 <= mb[ba0]; end
        if (rd1) begin id1 <= mi[ia1]; wd1 <= mw[wa1]; bd1 <= mb[ba1]; end
        if (rd2) begin id2 <= mi[ia2]; wd2 <= mw[wa2]; bd2 <= mb[ba2]; end
    end

    int          nin  [3] = '{4, 4, 784};
    int          nout [3] = '{3, 3, 10};
    int          rl   [3] = '{1, 0, 1};
    int          mrun [3] = '{0, 0, 0};
    int          mcyc [3] = '{0, 0, 0};
    int          ndone[3] = '{0, 0, 0};
    logic        msat [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] last_out[3];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Exact layer arithmetic on wide integers: bias*2^FRAC + dot product, floor-shift, clamp, ReLU.
    task automatic model_neuron(input int j, input int n_in, input int relu,
                                output logic [31:0] o, output logic cl);
        logic signed [127:0] acc, a, b, r;
        logic signed [127:0] mx, mn;
        mx  = 128'sd2147483647;
        mn  = -128'sd2147483648;
        acc = {{96{mb[j][31]}}, mb[j]};
        acc = acc <<< 24;
        for (int i = 0; i < n_in; i++) begin
            a   = {{96{mi[i][31]}}, mi[i]};
            b   = {{96{mw[j*n_in+i][31]}}, mw[j*n_in+i]};
            acc = acc + a * b;
        end
        r  = acc >>> 24;
        cl = (r > mx) || (r < mn);
        if (r > mx)      o = 32'h7FFFFFFF;
        else if (r < mn) o = 32'h80000000;
        else             o = r[31:0];
        if (relu != 0 && o[31]) o = 32'h0;
    endtask

    // Run position model: cycle 1 is the first MAC cycle; a run lasts N_OUT*(N_IN+2)+1 cycles.
    always @(posedge clk) begin : p_model
        logic s;
        int   tot;
        for (int k = 0; k < 3; k++) begin
            s   = (k == 2) ? start_d : start_s;
            tot = nout[k] * (nin[k] + 2);
            if (!rst_n) begin
                mrun[k] = 0; mcyc[k] = 0; msat[k] = 1'b0;
            end else if (mrun[k] != 0) begin
                if (mcyc[k] == tot + 1) begin mrun[k] = 0; mcyc[k] = 0; end
                else mcyc[k] = mcyc[k] + 1;
            end else if (s) begin
                mrun[k] = 1; mcyc[k] = 1; msat[k] = 1'b0;
            end
        end
    end

    task automatic check_inst(input int k, input logic busy, input logic done, input logic rd,
                              input int ia, input int wa, input int ba, input logic we,
                              input int oa, input logic [31:0] od, input logic sat);
        int          tot, j, pos;
        logic        e_rd, e_we, e_done, cl;
        logic [31:0] eo;
        tot = nout[k] * (nin[k] + 2);
        e_rd = 1'b0; e_we = 1'b0; e_done = 1'b0; j = 0; pos = 0;
        if (mrun[k] != 0) begin
            j      = (mcyc[k] - 1) / (nin[k] + 2);
            pos    = (mcyc[k] - 1) % (nin[k] + 2) + 1;
            e_rd   = (mcyc[k] <= tot) && (pos <= nin[k]);
            e_we   = (mcyc[k] <= tot) && (pos == nin[k] + 2);
            e_done = (mcyc[k] == tot + 1);
        end
        chk("busy", k, 32'(busy), 32'(mrun[k] != 0));
        chk("rd_en", k, 32'(rd), 32'(e_rd));
        chk("out_we", k, 32'(we), 32'(e_we));
        chk("done", k, 32'(done), 32'(e_done));
        if (e_rd) begin
            chk("in_addr", k, ia, pos - 1);
            chk("w_addr", k, wa, j * nin[k] + pos - 1);
            chk("b_addr", k, ba, j);
        end
        if (e_we) begin
            model_neuron(j, nin[k], rl[k], eo, cl);
            msat[k] = msat[k] | cl;
            chk("out_addr", k, oa, j);
            chk("out_data", k, od, eo);
            last_out[k] = od;
        end
        chk("sat", k, 32'(sat), 32'(msat[k]));
        if (done) ndone[k]++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, busy0, done0, rd0, int'(ia0), int'(wa0), int'(ba0), we0, int'(oa0), od0, sat0);
            check_inst(1, busy1, done1, rd1, int'(ia1), int'(wa1), int'(ba1), we1, int'(oa1), od1, sat1);
            check_inst(2, busy2, done2, rd2, int'(ia2), int'(wa2), int'(ba2), we2, int'(oa2), od2, sat2);
        end
    end

    task automatic load(input logic [31:0] vi, input logic [31:0] vw, input logic [31:0] vb);
        for (int i = 0; i < 784; i++)  mi[i] = vi;
        for (int i = 0; i < 7840; i++) mw[i] = vw;
        for (int i = 0; i < 10; i++)   mb[i] = vb;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while (mrun[k] != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (mrun[k] != 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL timeout[%0d] waited=%0d cycles, run still active", k, n);
        end
        @(negedge clk);
    endtask

    task automatic run_small();
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        wait_idle(0, 60);
    endtask

    initial begin : p_main
        logic [31:0] eo;
        logic        cl;
        int          nd, v;
        rst_n = 1'b0; start_s = 1'b0; start_d = 1'b0; chk_en = 1'b0;
        load(32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // T1: 4 x (1.0 * 0.5) = 2.0 per neuron
        load(32'h01000000, 32'h00800000, 32'h0);
        model_neuron(0, 4, 1, eo, cl);
        chk("pin_t1", 0, eo, 32'h02000000);
        run_small();
        chk("t1_out", 0, last_out[0], 32'h02000000);
        chk("t1_out", 1, last_out[1], 32'h02000000);

        // T2: 4 x (1.0 * -0.5) + 0.5 = -1.5; ReLU clamps to 0
        load(32'h01000000, 32'hFF800000, 32'h00800000);
        model_neuron(1, 4, 0, eo, cl);
        chk("pin_t2", 1, eo, 32'hFE800000);
        run_small();
        chk("t2_lin", 1, last_out[1], 32'hFE800000);
        chk("t2_relu", 0, last_out[0], 32'h0);

        // T3: max-by-max overflows positive range
        load(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
        run_small();
        chk("t3_out", 0, last_out[0], 32'h7FFFFFFF);
        chk("t3_sat", 0, 32'(sat0), 32'd1);
        chk("t3_sat", 1, 32'(sat1), 32'd1);

        // T3b: zero data passes bias through and clears sat
        load(32'h0, 32'h0, 32'h00300000);
        run_small();
        chk("t3b_out", 0, last_out[0], 32'h00300000);
        chk("t3b_sat", 0, 32'(sat0), 32'd0);

        // T4: start held across two runs
        load(32'h01000000, 32'h00800000, 32'h0);
        nd = ndone[0];
        @(negedge clk); start_s = 1'b1;
        repeat (30) @(negedge clk);
        start_s = 1'b0;
        wait_idle(0, 60);
        chk("t4_dones", 0, ndone[0] - nd, 2);

        // T5: reset in cycle 8 aborts, restart reproduces T1
        nd = ndone[0];
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", 0, 32'(busy0), 32'd0);
        chk("t5_rd_en", 0, 32'(rd0), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_nodone", 0, ndone[0] - nd, 0);
        last_out[0] = 32'hDEADBEEF;
        run_small();
        chk("t5_out", 0, last_out[0], 32'h02000000);
        chk("t5_dones", 0, ndone[0] - nd, 1);

        // T6: default geometry, random Q7.24 vectors
        for (int i = 0; i < 784; i++) begin v = int'($urandom); mi[i] = 32'(v >>> 6); end
        for (int i = 0; i < 7840; i++) begin v = int'($urandom); mw[i] = 32'(v >>> 10); end
        for (int i = 0; i < 10; i++) begin v = int'($urandom); mb[i] = 32'(v >>> 4); end
        nd = ndone[2];
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        wait_idle(2, 8000);
        chk("t6_dones", 2, ndone[2] - nd, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
